// File: rtl/slow_set_pkg.sv
// Shared constants for slow_set: default geometry, default channel mask and the
// bit positions of each settings field within the bus address.
package slow_set_pkg;

  localparam int unsigned DefNch = 6;
  localparam int unsigned DefTw  = 4;

  localparam logic [DefNch-1:0] DefRstMask = 6'b111011;

  // Address bits are numbered from 1, so field positions index A[AW:1] directly.
  localparam int unsigned CgBit   = 1;
  localparam int unsigned MaskLsb = 2;

  function automatic int unsigned timeout_lsb(int unsigned nch);
    return nch + 2;
  endfunction

  function automatic int unsigned lock_bit(int unsigned nch, int unsigned tw);
    return nch + tw + 2;
  endfunction

  function automatic int unsigned addr_width(int unsigned nch, int unsigned tw);
    return nch + tw + 2;
  endfunction

endpackage

// File: rtl/slow_set_window_ctr.sv
// Slow-window down-counter: loads on request, otherwise counts down to zero and
// holds there. running_o is a flop tracking whether the next count is nonzero.
module slow_window_ctr #(
  parameter int unsigned TW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic [TW-1:0] value_o,
  output logic          running_o
);

  logic [TW-1:0] cnt_d, cnt_q;
  logic          running_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      running_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      running_q <= (cnt_d != '0);
    end
  end

  assign value_o   = cnt_q;
  assign running_o = running_q;

endmodule

// File: rtl/slow_set.sv
// Slow-device settings register: a bus write is captured as pending and committed
// only while no slow window is running; a rising BACT to a masked channel opens one.
module slow_set
  import slow_set_pkg::*;
#(
  parameter int unsigned     NCH         = DefNch,
  parameter int unsigned     TW          = DefTw,
  parameter logic [NCH-1:0]  RST_MASK    = NCH'(DefRstMask),
  parameter logic [TW-1:0]   RST_TIMEOUT = {TW{1'b1}},
  localparam int unsigned    AW          = NCH + TW + 2
) (
  input  logic           CLK,
  input  logic           nPOR,
  input  logic           BACT,
  input  logic [AW:1]    A,
  input  logic           SetCSWR,
  input  logic [NCH-1:0] ChSel,
  output logic [NCH-1:0] SlowMask,
  output logic [TW-1:0]  SlowTimeout,
  output logic           SlowClockGate,
  output logic           Locked,
  output logic           SlowActive,
  output logic           PendValid
);

  localparam int unsigned ToLsb   = timeout_lsb(NCH);
  localparam int unsigned LockPos = lock_bit(NCH, TW);

  logic           wr_q, b_q;
  logic [AW:1]    pend_d, pend_q;
  logic           pv_d, pv_q;
  logic [NCH-1:0] mask_d, mask_q;
  logic [TW-1:0]  to_d, to_q;
  logic           cg_d, cg_q;
  logic           locked_d, locked_q;

  logic           wr_evt, trig, commit;
  logic [TW-1:0]  ctr_value;
  logic           ctr_running;

  assign wr_evt = BACT && SetCSWR && !wr_q;
  assign trig   = BACT && !b_q && ((ChSel & mask_q) != '0);
  // A trigger this cycle wins; the commit retries once the window has drained.
  assign commit = pv_q && (ctr_value == '0) && !trig;

  always_comb begin
    pend_d   = pend_q;
    pv_d     = pv_q;
    mask_d   = mask_q;
    to_d     = to_q;
    cg_d     = cg_q;
    locked_d = locked_q;
    if (commit) begin
      cg_d     = pend_q[CgBit];
      mask_d   = pend_q[MaskLsb +: NCH];
      to_d     = pend_q[ToLsb +: TW];
      locked_d = locked_q | pend_q[LockPos];
      pv_d     = 1'b0;
    end
    // Evaluated after the commit so a same-cycle write stays pending behind it.
    if (wr_evt && !locked_q) begin
      pend_d = A;
      pv_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      wr_q     <= 1'b0;
      b_q      <= 1'b0;
      pend_q   <= '0;
      pv_q     <= 1'b0;
      mask_q   <= RST_MASK;
      to_q     <= RST_TIMEOUT;
      cg_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      wr_q     <= BACT && SetCSWR;
      b_q      <= BACT;
      pend_q   <= pend_d;
      pv_q     <= pv_d;
      mask_q   <= mask_d;
      to_q     <= to_d;
      cg_q     <= cg_d;
      locked_q <= locked_d;
    end
  end

  slow_window_ctr #(
    .TW(TW)
  ) u_ctr (
    .clk_i     (CLK),
    .rst_ni    (nPOR),
    .load_i    (trig),
    .load_val_i(to_q),
    .value_o   (ctr_value),
    .running_o (ctr_running)
  );

  assign SlowMask      = mask_q;
  assign SlowTimeout   = to_q;
  assign SlowClockGate = cg_q;
  assign Locked        = locked_q;
  assign SlowActive    = ctr_running;
  assign PendValid     = pv_q;

endmodule
